miss_handler_arbiter: RTL and testbench
=======================================

Name: miss_handler_arbiter

Overview:
- Two-requester arbiter that shares one miss handler (refill / uncached memory engine) between the I-cache and D-cache sram-like cache interfaces.
- Each cache interface raises its handler request channel. The arbiter picks one owner, latches that owner's transaction, and drives the single miss-handler port until the handler reports finish.
- It then returns `fin` and `rdata` to the owner only.
- It sits between the two cache interfaces and the shared miss handler.

Parameters:
- BLKIDX_BIT, 4, width of the virtual block index forwarded to the miss handler.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- r0_req  in  1  requester 0 (I-cache) transaction request; held high until r0_fin.
- r0_cached  in  1  requester 0 cached (refill) vs uncached access.
- r0_w  in  1  requester 0 write flag (uncached only).
- r0_paddr  in  32  requester 0 physical word address.
- r0_blkidx  in  BLKIDX_BIT  requester 0 virtual block index.
- r0_wdata  in  32  requester 0 uncached write data.
- r0_wen  in  4  requester 0 uncached byte enables.
- r0_fin  out  1  one-cycle finish pulse to requester 0.
- r0_rdata  out  32  read data to requester 0; valid when r0_fin=1.
- r1_req, r1_cached, r1_w, r1_paddr, r1_blkidx, r1_wdata, r1_wen, r1_fin, r1_rdata: same as the r0_* ports, for requester 1 (D-cache).
- m_req  out  1  request to miss handler.
- m_cached  out  1  latched cached flag.
- m_w  out  1  latched write flag.
- m_paddr  out  32  latched address.
- m_blkidx  out  BLKIDX_BIT  latched block index.
- m_wdata  out  32  latched write data.
- m_wen  out  4  latched byte enables.
- m_fin  in  1  miss handler finished; valid response this cycle.
- m_rdata  in  32  miss handler read data; valid when m_fin=1.
- owner  out  1  current/last granted requester (0 or 1), for debug and mux control.

Behaviour:
- State machine: IDLE, GRANT, DRAIN.
- Reset: state=IDLE, m_req=0, all m_* payload registers=0, r0_fin=r1_fin=0, owner=0, priority pointer=0 (requester 0 favoured first).

IDLE:
- If no requester is asking: stay in IDLE, m_req=0.
- If exactly one of r0_req/r1_req is high: grant it.
- If both are high: grant the requester pointed to by the round-robin pointer.
- On grant (registered):
  - owner <= winner.
  - m_* payload <= winner's inputs.
  - state <= GRANT.
  - pointer <= ~winner.
- Grant latency: m_req first goes high one cycle after the winning req is sampled.

GRANT:
- m_req=1; payload held constant regardless of requester input changes.
- On m_fin=1:
  - The owner's rN_fin goes high combinationally in that same cycle; the other rN_fin stays 0.
  - rN_rdata = m_rdata.
  - state <= DRAIN.
- The non-owner's rN_rdata is driven 0.

DRAIN:
- Exactly one cycle, m_req=0. This gives the owner's FSM time to drop req after fin, so it is not re-granted on a stale request.
- Then state <= IDLE.
- Arbitration happens in the IDLE cycle that follows.

Boundary conditions:
- Owner drops req while in GRANT (abort): ignored. The transaction runs to m_fin and fin is still pulsed.
- m_fin while in IDLE or DRAIN: ignored; no rN_fin is generated.
- m_fin in the first GRANT cycle is legal and is the minimum latency.
- Both requesters held continuously high: grants strictly alternate 0,1,0,1. Worst-case wait is one full transaction plus 2 cycles.
- Reset mid-transaction: state forced to IDLE the next cycle, m_req=0, no fin pulsed.
- m_rdata passes to rN_rdata combinationally; it is not registered.

Optional Feature:
- Macro: ARB_DCACHE_PRIO_EN.
- Defined: fixed priority. Requester 1 (D-cache) always wins a simultaneous request in IDLE. The round-robin pointer is neither used nor updated.
- Undefined: round-robin as described above.

Test Plan:
- Single request: r0_req=1, r0_paddr=0x1FC0_0040, r0_cached=1, m_fin asserted 5 cycles after m_req.
  - Required: m_req rises 1 cycle after r0_req.
  - Required: m_paddr=0x1FC0_0040.
  - Required: r0_fin pulses once with r0_rdata=m_rdata=0xDEAD_BEEF; r1_fin stays 0.
- Simultaneous requests, both held until each one's own fin: after reset the order is r0 then r1.
  - Required: m_paddr switches from r0_paddr to r1_paddr exactly 2 cycles after the first m_fin (DRAIN + IDLE).
- Payload stability: change r1_paddr and r1_wdata every cycle during GRANT with owner=1.
  - Required: m_paddr/m_wdata stay equal to the values sampled at grant.
- Abort and spurious fin:
  - Drop r0_req mid-GRANT. Required: m_req stays 1 until m_fin; r0_fin still pulses.
  - Pulse m_fin in IDLE. Required: no rN_fin.
- Reset mid-GRANT (rst=1 for 1 cycle): state IDLE, m_req=0, no fin, pointer back to 0.
- With ARB_DCACHE_PRIO_EN defined, both requesters continuously high for 4 transactions:
  - Required: all 4 grants go to requester 1; r0_fin stays 0.

Source files
------------

// File: rtl/miss_handler_arbiter_if.sv
// Bundle of the two cache-side request channels and the shared miss-handler port.
// The master side is the surrounding system (caches + handler); the slave side is the arbiter.
interface miss_handler_arbiter_if #(
  parameter int BLKIDX_BIT = 4
);
  logic                  r0_req;
  logic                  r0_cached;
  logic                  r0_w;
  logic [31:0]           r0_paddr;
  logic [BLKIDX_BIT-1:0] r0_blkidx;
  logic [31:0]           r0_wdata;
  logic [3:0]            r0_wen;
  logic                  r0_fin;
  logic [31:0]           r0_rdata;

  logic                  r1_req;
  logic                  r1_cached;
  logic                  r1_w;
  logic [31:0]           r1_paddr;
  logic [BLKIDX_BIT-1:0] r1_blkidx;
  logic [31:0]           r1_wdata;
  logic [3:0]            r1_wen;
  logic                  r1_fin;
  logic [31:0]           r1_rdata;

  logic                  m_req;
  logic                  m_cached;
  logic                  m_w;
  logic [31:0]           m_paddr;
  logic [BLKIDX_BIT-1:0] m_blkidx;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wen;
  logic                  m_fin;
  logic [31:0]           m_rdata;

  modport master (
    output r0_req, r0_cached, r0_w, r0_paddr, r0_blkidx, r0_wdata, r0_wen,
    input  r0_fin, r0_rdata,
    output r1_req, r1_cached, r1_w, r1_paddr, r1_blkidx, r1_wdata, r1_wen,
    input  r1_fin, r1_rdata,
    input  m_req, m_cached, m_w, m_paddr, m_blkidx, m_wdata, m_wen,
    output m_fin, m_rdata
  );

  modport slave (
    input  r0_req, r0_cached, r0_w, r0_paddr, r0_blkidx, r0_wdata, r0_wen,
    output r0_fin, r0_rdata,
    input  r1_req, r1_cached, r1_w, r1_paddr, r1_blkidx, r1_wdata, r1_wen,
    output r1_fin, r1_rdata,
    output m_req, m_cached, m_w, m_paddr, m_blkidx, m_wdata, m_wen,
    input  m_fin, m_rdata
  );
endinterface

// File: rtl/miss_handler_arbiter.sv
// Shares one miss handler between the I-cache (requester 0) and D-cache (requester 1).
// Define ARB_DCACHE_PRIO_EN for fixed D-cache priority; default build is round-robin.
module miss_handler_arbiter #(
  parameter int BLKIDX_BIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  miss_handler_arbiter_if.slave        bus,
  output logic                         owner
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_p0;
  state_t                state_nxt;
  logic                  owner_p0;
  logic                  cached_p0;
  logic                  w_p0;
  logic [DATA_W-1:0]     paddr_p0;
  logic [BLKIDX_BIT-1:0] blkidx_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [3:0]            wen_p0;

  logic                  any_req;
  logic                  winner;
  logic                  grant;
  logic                  fin_vld;

  logic                  sel_cached;
  logic                  sel_w;
  logic [DATA_W-1:0]     sel_paddr;
  logic [BLKIDX_BIT-1:0] sel_blkidx;
  logic [DATA_W-1:0]     sel_wdata;
  logic [3:0]            sel_wen;

`ifdef ARB_DCACHE_PRIO_EN
  always_comb begin
    winner = bus.r1_req;
  end
`else
  logic ptr_p0;

  // Both asking: the pointer decides; otherwise whoever is asking wins.
  always_comb begin
    winner = (bus.r0_req & bus.r1_req) ? ptr_p0 : bus.r1_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0 <= 1'b0;
    end else if (grant) begin
      ptr_p0 <= ~winner;
    end
  end
`endif

  always_comb begin
    any_req   = bus.r0_req | bus.r1_req;
    grant     = 1'b0;
    state_nxt = state_p0;
    case (state_p0)
      IDLE: begin
        if (any_req) begin
          grant     = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (bus.m_fin) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_cached = winner ? bus.r1_cached : bus.r0_cached;
    sel_w      = winner ? bus.r1_w      : bus.r0_w;
    sel_paddr  = winner ? bus.r1_paddr  : bus.r0_paddr;
    sel_blkidx = winner ? bus.r1_blkidx : bus.r0_blkidx;
    sel_wdata  = winner ? bus.r1_wdata  : bus.r0_wdata;
    sel_wen    = winner ? bus.r1_wen    : bus.r0_wen;
  end

  // Stage p0: transaction latched at grant, held until the handler finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      owner_p0  <= 1'b0;
      cached_p0 <= 1'b0;
      w_p0      <= 1'b0;
      paddr_p0  <= '0;
      blkidx_p0 <= '0;
      wdata_p0  <= '0;
      wen_p0    <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (grant) begin
        owner_p0  <= winner;
        cached_p0 <= sel_cached;
        w_p0      <= sel_w;
        paddr_p0  <= sel_paddr;
        blkidx_p0 <= sel_blkidx;
        wdata_p0  <= sel_wdata;
        wen_p0    <= sel_wen;
      end
    end
  end

  // Response path is combinational; a finish seen outside GRANT or under reset is dropped.
  always_comb begin
    fin_vld      = (state_p0 == GRANT) & bus.m_fin & ~rst;
    bus.m_req    = (state_p0 == GRANT);
    bus.m_cached = cached_p0;
    bus.m_w      = w_p0;
    bus.m_paddr  = paddr_p0;
    bus.m_blkidx = blkidx_p0;
    bus.m_wdata  = wdata_p0;
    bus.m_wen    = wen_p0;
    bus.r0_fin   = fin_vld & ~owner_p0;
    bus.r1_fin   = fin_vld &  owner_p0;
    bus.r0_rdata = owner_p0 ? '0 : bus.m_rdata;
    bus.r1_rdata = owner_p0 ? bus.m_rdata : '0;
    owner        = owner_p0;
  end

endmodule

// File: tb/tb_miss_handler_arbiter.sv
// Directed bench for miss_handler_arbiter: transaction-level model checked every cycle
// plus literal expectations for the key scenarios.
module tb_miss_handler_arbiter;

  localparam int BLKIDX_BIT = 4;
`ifdef ARB_DCACHE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic owner;

  miss_handler_arbiter_if #(.BLKIDX_BIT(BLKIDX_BIT)) bus ();

  miss_handler_arbiter #(.BLKIDX_BIT(BLKIDX_BIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  // Transaction-level model: one outstanding transaction, then a dead gap before re-arbitration.
  bit          armed = 1'b0;
  bit          mdl_busy;
  int          mdl_gap;
  bit          mdl_own;
  bit          mdl_ptr;
  bit          mdl_win;
  bit          mdl_fin;
  logic [41:0] mdl_ctrl;   // {cached, w, wen, blkidx, paddr}
  logic [31:0] mdl_wdata;

  always @(negedge clk) begin
    if (armed) begin
      mdl_fin = mdl_busy && bus.m_fin && !rst;
      check1 ("m_req",    bus.m_req, mdl_busy);
      check1 ("owner",    owner, mdl_own);
      check32("m_paddr",  bus.m_paddr, mdl_ctrl[31:0]);
      check32("m_ctrl",   32'({bus.m_cached, bus.m_w, bus.m_wen, bus.m_blkidx}), 32'(mdl_ctrl[41:32]));
      check32("m_wdata",  bus.m_wdata, mdl_wdata);
      check1 ("r0_fin",   bus.r0_fin, mdl_fin && !mdl_own);
      check1 ("r1_fin",   bus.r1_fin, mdl_fin && mdl_own);
      check32("r0_rdata", bus.r0_rdata, mdl_own ? 32'h0 : bus.m_rdata);
      check32("r1_rdata", bus.r1_rdata, mdl_own ? bus.m_rdata : 32'h0);
    end
    if (rst) begin
      armed     = 1'b1;
      mdl_busy  = 1'b0;
      mdl_gap   = 0;
      mdl_own   = 1'b0;
      mdl_ptr   = 1'b0;
      mdl_ctrl  = '0;
      mdl_wdata = '0;
    end else if (mdl_busy) begin
      if (bus.m_fin) begin
        mdl_busy = 1'b0;
        mdl_gap  = 1;
      end
    end else if (mdl_gap > 0) begin
      mdl_gap = mdl_gap - 1;
    end else if (bus.r0_req || bus.r1_req) begin
      if (PRIO) mdl_win = bus.r1_req;
      else begin
        mdl_win = (bus.r0_req && bus.r1_req) ? mdl_ptr : bus.r1_req;
        mdl_ptr = !mdl_win;
      end
      mdl_own  = mdl_win;
      mdl_busy = 1'b1;
      if (mdl_win) begin
        mdl_ctrl  = {bus.r1_cached, bus.r1_w, bus.r1_wen, bus.r1_blkidx, bus.r1_paddr};
        mdl_wdata = bus.r1_wdata;
      end else begin
        mdl_ctrl  = {bus.r0_cached, bus.r0_w, bus.r0_wen, bus.r0_blkidx, bus.r0_paddr};
        mdl_wdata = bus.r0_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fin(input logic [31:0] data);
    bus.m_fin   = 1'b1;
    bus.m_rdata = data;
    #1;
  endtask

  initial begin
    int waited;
    bus.r0_req = 0; bus.r0_cached = 0; bus.r0_w = 0; bus.r0_paddr = 0;
    bus.r0_blkidx = 0; bus.r0_wdata = 0; bus.r0_wen = 0;
    bus.r1_req = 0; bus.r1_cached = 0; bus.r1_w = 0; bus.r1_paddr = 0;
    bus.r1_blkidx = 0; bus.r1_wdata = 0; bus.r1_wen = 0;
    bus.m_fin = 0; bus.m_rdata = 0;

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check1 ("rst_m_req", bus.m_req, 1'b0);
    check1 ("rst_owner", owner, 1'b0);
    check32("rst_m_paddr", bus.m_paddr, 32'h0);
    check1 ("rst_r0_fin", bus.r0_fin, 1'b0);

    // Single request from the I-cache
    bus.r0_req = 1; bus.r0_cached = 1; bus.r0_paddr = 32'h1FC0_0040; bus.r0_blkidx = 4'h5;
    check1("t1_m_req_before", bus.m_req, 1'b0);
    tick();
    check1 ("t1_m_req_rise", bus.m_req, 1'b1);
    check32("t1_m_paddr", bus.m_paddr, 32'h1FC0_0040);
    repeat (5) tick();
    pulse_fin(32'hDEAD_BEEF);
    check1 ("t1_r0_fin", bus.r0_fin, 1'b1);
    check32("t1_r0_rdata", bus.r0_rdata, 32'hDEAD_BEEF);
    check1 ("t1_r1_fin", bus.r1_fin, 1'b0);
    tick();
    bus.m_fin = 0; bus.r0_req = 0;
    check1("t1_r0_fin_once", bus.r0_fin, 1'b0);

    // Simultaneous requests after reset
    rst = 1; tick(); rst = 0;
    bus.r0_req = 1; bus.r0_paddr = 32'h0000_1000; bus.r0_cached = 1;
    bus.r1_req = 1; bus.r1_paddr = 32'h8000_2000; bus.r1_cached = 0; bus.r1_w = 1;
    bus.r1_wdata = 32'h1234_5678; bus.r1_wen = 4'hC; bus.r1_blkidx = 4'hA;
    tick();
    check1 ("t2_first_owner", owner, PRIO);
    check32("t2_first_paddr", bus.m_paddr, PRIO ? 32'h8000_2000 : 32'h0000_1000);
    if (!PRIO) begin
      tick();
      pulse_fin(32'h0A0A_0A0A);
      check1("t2_r0_fin", bus.r0_fin, 1'b1);
      tick();
      bus.m_fin = 0; bus.r0_req = 0;
      check1 ("t2_drain_m_req", bus.m_req, 1'b0);
      check32("t2_drain_paddr", bus.m_paddr, 32'h0000_1000);
      tick();
      check1 ("t2_idle_m_req", bus.m_req, 1'b0);
      check32("t2_idle_paddr", bus.m_paddr, 32'h0000_1000);
      tick();
      check1 ("t2_second_m_req", bus.m_req, 1'b1);
      check32("t2_second_paddr", bus.m_paddr, 32'h8000_2000);
      check1 ("t2_second_owner", owner, 1'b1);
    end else begin
      bus.r0_req = 0;
    end

    // Payload held while requester 1 keeps changing its inputs
    for (int i = 0; i < 4; i++) begin
      bus.r1_paddr = 32'hF000_0000 + 32'(i);
      bus.r1_wdata = ~32'(i);
      tick();
      check32("t3_m_paddr", bus.m_paddr, 32'h8000_2000);
      check32("t3_m_wdata", bus.m_wdata, 32'h1234_5678);
    end
    check32("t3_m_ctrl", 32'({bus.m_cached, bus.m_w, bus.m_wen, bus.m_blkidx}), 32'({1'b0, 1'b1, 4'hC, 4'hA}));
    pulse_fin(32'hCAFE_F00D);
    check1 ("t3_r1_fin", bus.r1_fin, 1'b1);
    check32("t3_r1_rdata", bus.r1_rdata, 32'hCAFE_F00D);
    check1 ("t3_r0_fin", bus.r0_fin, 1'b0);
    check32("t3_r0_rdata", bus.r0_rdata, 32'h0);
    tick();
    bus.m_fin = 0; bus.r1_req = 0; bus.r1_w = 0;

    // Requester 0 aborts mid-transaction
    tick();
    bus.r0_req = 1; bus.r0_paddr = 32'h2000_0000;
    tick();
    check1("t4_granted", bus.m_req, 1'b1);
    check1("t4_owner", owner, 1'b0);
    bus.r0_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("t4_m_req_held", bus.m_req, 1'b1);
    end
    pulse_fin(32'h55AA_55AA);
    check1 ("t4_r0_fin", bus.r0_fin, 1'b1);
    check32("t4_r0_rdata", bus.r0_rdata, 32'h55AA_55AA);
    tick();

    // Spurious finish in DRAIN and IDLE
    #1;
    check1("t5_drain_r0_fin", bus.r0_fin, 1'b0);
    check1("t5_drain_r1_fin", bus.r1_fin, 1'b0);
    tick();
    check1("t5_idle_r0_fin", bus.r0_fin, 1'b0);
    check1("t5_idle_r1_fin", bus.r1_fin, 1'b0);
    check1("t5_idle_m_req", bus.m_req, 1'b0);
    tick();
    bus.m_fin = 0;
    check1("t5_still_idle", bus.m_req, 1'b0);

    // Reset in the middle of a grant
    bus.r0_req = 1;
    tick();
    check1("t6_granted", bus.m_req, 1'b1);
    bus.r0_req = 0;
    tick();
    rst = 1;
    #1;
    check1("t6_no_fin_in_rst", bus.r0_fin, 1'b0);
    tick();
    rst = 0;
    check1("t6_m_req_cleared", bus.m_req, 1'b0);
    check1("t6_owner_cleared", owner, 1'b0);
    bus.r0_req = 1; bus.r1_req = 1;
    tick();
    check1("t6_owner_after_rst", owner, PRIO);
    pulse_fin(32'h0000_0006);
    tick();
    bus.m_fin = 0;

    // Both held high: grants alternate (or stay with requester 1 under fixed priority)
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      while (!bus.m_req && waited < 8) begin
        tick();
        waited++;
      end
      check1 ("t7_grant_seen", bus.m_req, 1'b1);
      check32("t7_gap_cycles", 32'(waited), 32'd2);
      check1 ("t7_owner", owner, PRIO ? 1'b1 : ((n % 2) == 0));
      pulse_fin(32'h7000_0000 + 32'(n));
      tick();
      bus.m_fin = 0;
    end
    bus.r0_req = 0; bus.r1_req = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
